// File: rtl/fifo_stream_out.sv
// -----------------------------------------------------------------------------
// fifo_stream_out
//
// Drain stage that sits behind the synchronous FIFO and turns its
// pop/empty/out_data read port into a valid/ready stream.
//
// The FIFO has a one-cycle registered read: data popped in cycle T appears on
// fifo_out_data in cycle T+1. An "inflight" flag remembers an outstanding pop
// so that the word is captured into a 2-entry elastic buffer on the following
// edge. The stream is presented from the buffer head, so a word popped in
// cycle T is on m_data with m_valid=1 in cycle T+2. With the sink always
// ready, one beat per cycle is sustained once the first word has arrived.
//
// Every BURST_LEN beats, the final beat of the frame is flagged with m_last.
// frame_count counts completed frames and wraps modulo 2^16.
//
// Build option:
//   FIFO_STREAM_OUT_STALL_CNT_EN - when defined, stall_cycles counts cycles
//   with m_valid=1 and m_ready=0, saturating at 16'hFFFF. When undefined,
//   stall_cycles is tied to zero and no counter is built.
//
// Parameters:
//   DATA_WIDTH - width of the FIFO read data and of the stream data
//   BURST_LEN  - beats per frame, 1..256
//
// Ports:
//   clk           in   clock, rising edge
//   rstn          in   asynchronous active-low reset
//   en            in   drain enable; no new pops while low
//   fifo_empty    in   FIFO empty flag
//   fifo_pop      out  pop request to the FIFO
//   fifo_out_data in   FIFO read data, valid the cycle after a pop
//   m_valid       out  stream data valid
//   m_ready       in   stream sink ready
//   m_data        out  stream data (buffer head)
//   m_last        out  final beat of the current frame
//   frame_count   out  completed frames, wraps
//   busy          out  a pop is outstanding or the buffer holds data
//   stall_cycles  out  backpressure cycle counter (build option)
// -----------------------------------------------------------------------------
module fifo_stream_out #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [DATA_WIDTH-1:0] fifo_out_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [15:0]           frame_count,
   output logic                  busy,
   output logic [15:0]           stall_cycles
);

   localparam int BEAT_W = $clog2(BURST_LEN) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] buf_reg [2];
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic [1:0]            occ_reg;
   logic [1:0]            occ_next;
   logic                  inflight_reg;
   logic [BEAT_W-1:0]     beat_reg;
   logic [BEAT_W-1:0]     beat_next;
   logic [15:0]           frame_count_reg;
   logic [15:0]           frame_count_next;

   logic                  xfer;
   logic                  capture;
   logic [2:0]            pending;

   // ---------------------------------------------------------------------
   // Handshake and pop decision
   // ---------------------------------------------------------------------
   assign m_valid = (occ_reg != 2'd0);
   assign xfer    = m_valid & m_ready;
   assign capture = inflight_reg;

   // Words that will occupy the buffer after this edge if no new pop is made:
   // current occupancy plus the word already on its way, minus the one
   // leaving now. A new pop is only allowed when that leaves room for it.
   // xfer implies occ_reg != 0, so the subtraction cannot underflow.
   assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, xfer};

   // rstn gates the pop so that nothing is requested while held in reset;
   // the first pop then happens in the cycle reset is released.
   assign fifo_pop = rstn & en & ~fifo_empty & (pending < 3'd2);

   // ---------------------------------------------------------------------
   // Inflight flag: one outstanding read at most per cycle
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= fifo_pop;
      end
   end

   // ---------------------------------------------------------------------
   // Elastic buffer storage: one register per entry, written at the tail
   // when the read data of an earlier pop arrives.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               buf_reg[gi] <= '0;
            end else if (capture && (wr_ptr_reg == 1'(gi))) begin
               buf_reg[gi] <= fifo_out_data;
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Pointers and occupancy
   // ---------------------------------------------------------------------
   always_comb begin
      occ_next = occ_reg;
      case ({capture, xfer})
         2'b10:   occ_next = occ_reg + 2'd1;
         2'b01:   occ_next = occ_reg - 2'd1;
         default: occ_next = occ_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         occ_reg    <= 2'd0;
      end else begin
         if (capture) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (xfer) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         occ_reg <= occ_next;
      end
   end

   assign m_data = buf_reg[rd_ptr_reg];
   assign busy   = inflight_reg | (occ_reg != 2'd0);

   // ---------------------------------------------------------------------
   // Frame tracking. The beat count only advances on a transfer, so pauses
   // (en low, FIFO empty, backpressure) never shift the frame boundary.
   // ---------------------------------------------------------------------
   assign m_last = m_valid & (beat_reg == LAST_BEAT);

   always_comb begin
      beat_next        = beat_reg;
      frame_count_next = frame_count_reg;
      if (xfer) begin
         if (m_last) begin
            beat_next        = '0;
            frame_count_next = frame_count_reg + 16'd1;
         end else begin
            beat_next = beat_reg + BEAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_reg        <= '0;
         frame_count_reg <= 16'd0;
      end else begin
         beat_reg        <= beat_next;
         frame_count_reg <= frame_count_next;
      end
   end

   assign frame_count = frame_count_reg;

   // ---------------------------------------------------------------------
   // Backpressure counter
   // ---------------------------------------------------------------------
`ifdef FIFO_STREAM_OUT_STALL_CNT_EN
   logic [15:0] stall_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_reg <= 16'd0;
      end else if (m_valid && !m_ready && (stall_reg != 16'hFFFF)) begin
         stall_reg <= stall_reg + 16'd1;
      end
   end

   assign stall_cycles = stall_reg;
`else
   assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_out
//
// Directed bench for fifo_stream_out with BURST_LEN=4 and DATA_WIDTH=32.
// A small behavioural FIFO with a one-cycle registered read feeds the DUT.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Received beats are logged as {m_last, m_data}.
// -----------------------------------------------------------------------------
module tb_fifo_stream_out;

   localparam int DW = 32;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic          en;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [DW-1:0] fifo_out_data = '0;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [15:0]   frame_count;
   logic          busy;
   logic [15:0]   stall_cycles;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fifo_stream_out #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .en            (en),
      .fifo_empty    (fifo_empty),
      .fifo_pop      (fifo_pop),
      .fifo_out_data (fifo_out_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_last        (m_last),
      .frame_count   (frame_count),
      .busy          (busy),
      .stall_cycles  (stall_cycles)
   );

   // ---------------- behavioural FIFO (registered read) ----------------
   logic [DW-1:0] fmem [256];
   int f_wr = 0;
   int f_rd = 0;

   assign fifo_empty = (f_wr == f_rd);

   always @(posedge clk) begin
      if (fifo_pop && (f_rd != f_wr)) begin
         fifo_out_data <= fmem[f_rd[7:0]];
         f_rd          <= f_rd + 1;
      end
   end

   task automatic push(input logic [DW-1:0] d);
      fmem[f_wr[7:0]] = d;
      f_wr = f_wr + 1;
   endtask

   // ---------------- monitors ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW:0] rx_q [$];
   int          rx_cyc [$];
   int          pops_seen = 0;

   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic          prev_last  = 1'b0;

   always @(negedge clk) begin
      if (rstn) begin
         if (m_valid && m_ready) begin
            rx_q.push_back({m_last, m_data});
            rx_cyc.push_back(cyc);
         end
         if (fifo_pop) begin
            pops_seen = pops_seen + 1;
            checks = checks + 1;
            if (fifo_empty !== 1'b0) begin
               errors = errors + 1;
               $display("FAIL pop_on_empty: fifo_pop=1 with fifo_empty=%b, required no pop", fifo_empty);
            end
         end
         if (prev_stall) begin
            checks = checks + 1;
            if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
               errors = errors + 1;
               $display("FAIL hold_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                        m_valid, m_data, m_last, prev_data, prev_last);
            end
         end
         prev_stall = m_valid & ~m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // ---------------- helpers (stimulus/waiting only) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (!busy && fifo_empty) done = 1;
      end
      checks = checks + 1;
      if (!done) begin
         errors = errors + 1;
         $display("FAIL %s_timeout: got busy=%b empty=%b after 100 cycles, required idle", name, busy, fifo_empty);
      end
      step();
   endtask

   task automatic do_reset();
      step();
      rstn = 1'b0;
      step();
      step();
      rx_q.delete();
      rx_cyc.delete();
      rstn = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0;
      en = 1'b1;
      m_ready = 1'b0;
      push(32'hA0); push(32'hA1); push(32'hA2);
      @(negedge clk);
      checks = checks + 1;
      if ({fifo_pop, m_valid, m_last, busy} !== 4'b0000 || frame_count !== 16'd0 ||
          m_data !== '0 || stall_cycles !== 16'd0) begin
         errors = errors + 1;
         $display("FAIL reset_outputs: got pop=%b v=%b l=%b busy=%b fc=%0d d=%h st=%0d, required all 0",
                  fifo_pop, m_valid, m_last, busy, frame_count, m_data, stall_cycles);
      end
      step();
      rstn = 1'b1;
      @(negedge clk);
      checks = checks + 1;
      if (fifo_pop !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL reset_first_pop: got fifo_pop=%b, required 1", fifo_pop);
      end
      @(negedge clk);
      checks = checks + 1;
      if (m_valid !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_latency_t1: got m_valid=%b, required 0", m_valid);
      end
      @(negedge clk);
      checks = checks + 1;
      if (m_valid !== 1'b1 || m_data !== 32'hA0) begin
         errors = errors + 1;
         $display("FAIL reset_latency_t2: got v=%b d=%h, required v=1 d=000000a0", m_valid, m_data);
      end
      step();
      m_ready = 1'b1;
      wait_idle("reset_drain");
      checks = checks + 1;
      if (rx_q.size() !== 3) begin
         errors = errors + 1;
         $display("FAIL reset_count: got %0d beats, required 3", rx_q.size());
      end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         checks = checks + 1;
         if (rx_q[i] !== {1'b0, 32'hA0 + 32'(i)}) begin
            errors = errors + 1;
            $display("FAIL reset_beat%0d: got %h, required %h", i, rx_q[i], {1'b0, 32'hA0 + 32'(i)});
         end
      end
   endtask

   task automatic test_streaming();
      do_reset();
      en = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
      en = 1'b1;
      wait_idle("stream");
      checks = checks + 1;
      if (rx_q.size() !== 8) begin
         errors = errors + 1;
         $display("FAIL stream_count: got %0d beats, required 8", rx_q.size());
      end
      for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
         checks = checks + 1;
         if (rx_q[i] !== {(i == 3 || i == 7), 32'h10 + 32'(i)} || rx_cyc[i] - rx_cyc[0] != i) begin
            errors = errors + 1;
            $display("FAIL stream_beat%0d: got %h at +%0d, required %h at +%0d",
                     i, rx_q[i], rx_cyc[i] - rx_cyc[0], {(i == 3 || i == 7), 32'h10 + 32'(i)}, i);
         end
      end
      checks = checks + 1;
      if (frame_count !== 16'd2) begin
         errors = errors + 1;
         $display("FAIL stream_frames: got %0d, required 2", frame_count);
      end
   endtask

   task automatic test_backpressure();
      int pops_before;
      bit got2 = 0;
      do_reset();
      en = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
      en = 1'b1;
      for (int i = 0; i < 20 && !got2; i++) begin
         @(negedge clk);
         if (rx_q.size() >= 2) got2 = 1;
      end
      checks = checks + 1;
      if (!got2) begin
         errors = errors + 1;
         $display("FAIL bp_start_timeout: got %0d beats, required 2", rx_q.size());
      end
      step();
      m_ready = 1'b0;
      pops_before = pops_seen;
      repeat (5) step();
      checks = checks + 1;
      if (pops_seen - pops_before > 2) begin
         errors = errors + 1;
         $display("FAIL bp_pops: got %0d pops during stall, required at most 2", pops_seen - pops_before);
      end
      checks = checks + 1;
`ifdef FIFO_STREAM_OUT_STALL_CNT_EN
      if (stall_cycles !== 16'd5) begin
         errors = errors + 1;
         $display("FAIL bp_stall_cnt: got %0d, required 5", stall_cycles);
      end
`else
      if (stall_cycles !== 16'd0) begin
         errors = errors + 1;
         $display("FAIL bp_stall_cnt: got %0d, required 0", stall_cycles);
      end
`endif
      m_ready = 1'b1;
      wait_idle("bp");
      checks = checks + 1;
      if (rx_q.size() !== 8) begin
         errors = errors + 1;
         $display("FAIL bp_count: got %0d beats, required 8", rx_q.size());
      end
      for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
         checks = checks + 1;
         if (rx_q[i] !== {(i == 3 || i == 7), 32'h20 + 32'(i)}) begin
            errors = errors + 1;
            $display("FAIL bp_beat%0d: got %h, required %h", i, rx_q[i], {(i == 3 || i == 7), 32'h20 + 32'(i)});
         end
      end
      checks = checks + 1;
      if (frame_count !== 16'd2) begin
         errors = errors + 1;
         $display("FAIL bp_frames: got %0d, required 2", frame_count);
      end
   endtask

   task automatic test_empty_boundary();
      do_reset();
      en = 1'b1;
      m_ready = 1'b1;
      push(32'h30); push(32'h31); push(32'h32);
      wait_idle("empty_a");
      checks = checks + 1;
      if (rx_q.size() !== 3 || m_valid !== 1'b0 || frame_count !== 16'd0) begin
         errors = errors + 1;
         $display("FAIL empty_partial: got beats=%0d v=%b fc=%0d, required 3 0 0", rx_q.size(), m_valid, frame_count);
      end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         checks = checks + 1;
         if (rx_q[i] !== {1'b0, 32'h30 + 32'(i)}) begin
            errors = errors + 1;
            $display("FAIL empty_beat%0d: got %h, required %h", i, rx_q[i], {1'b0, 32'h30 + 32'(i)});
         end
      end
      repeat (3) step();
      push(32'h33);
      wait_idle("empty_b");
      checks = checks + 1;
      if (rx_q.size() !== 4 || (rx_q.size() == 4 && rx_q[3] !== {1'b1, 32'h33}) || frame_count !== 16'd1) begin
         errors = errors + 1;
         $display("FAIL empty_resume: got beats=%0d last=%h fc=%0d, required 4 100000033 1",
                  rx_q.size(), rx_q[rx_q.size()-1], frame_count);
      end
   endtask

   task automatic test_enable_gating();
      int pops_before;
      do_reset();
      en = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(32'h40 + 32'(i));
      pops_before = pops_seen;
      en = 1'b1;
      step();
      en = 1'b0;
      repeat (6) step();
      checks = checks + 1;
      if (pops_seen - pops_before !== 1) begin
         errors = errors + 1;
         $display("FAIL en_pops: got %0d pops, required 1", pops_seen - pops_before);
      end
      checks = checks + 1;
      if (rx_q.size() !== 1 || (rx_q.size() == 1 && rx_q[0] !== {1'b0, 32'h40})) begin
         errors = errors + 1;
         $display("FAIL en_inflight: got beats=%0d, required one beat 040", rx_q.size());
      end
      @(negedge clk);
      checks = checks + 1;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL en_busy: got busy=%b v=%b, required 0 0", busy, m_valid);
      end
      step();
      en = 1'b1;
      wait_idle("en");
      for (int i = 1; i < 4; i++) begin
         checks = checks + 1;
         if (i >= rx_q.size() || rx_q[i] !== {(i == 3), 32'h40 + 32'(i)}) begin
            errors = errors + 1;
            $display("FAIL en_resume%0d: got beats=%0d, required %h", i, rx_q.size(), {(i == 3), 32'h40 + 32'(i)});
         end
      end
   endtask

   task automatic test_mid_frame_reset();
      do_reset();
      en = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(32'h50 + 32'(i));
      wait_idle("mfr_a");
      checks = checks + 1;
      if (frame_count !== 16'd1) begin
         errors = errors + 1;
         $display("FAIL mfr_pre: got fc=%0d, required 1", frame_count);
      end
      do_reset();
      @(negedge clk);
      checks = checks + 1;
      if (frame_count !== 16'd0 || m_valid !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL mfr_cleared: got fc=%0d v=%b, required 0 0", frame_count, m_valid);
      end
      step();
      for (int i = 0; i < 4; i++) push(32'h60 + 32'(i));
      wait_idle("mfr_b");
      for (int i = 0; i < 4; i++) begin
         checks = checks + 1;
         if (i >= rx_q.size() || rx_q[i] !== {(i == 3), 32'h60 + 32'(i)}) begin
            errors = errors + 1;
            $display("FAIL mfr_beat%0d: got beats=%0d, required %h", i, rx_q.size(), {(i == 3), 32'h60 + 32'(i)});
         end
      end
      checks = checks + 1;
      if (frame_count !== 16'd1) begin
         errors = errors + 1;
         $display("FAIL mfr_frames: got %0d, required 1", frame_count);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_empty_boundary();
      test_enable_gating();
      test_mid_frame_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
